// File: rtl/census_hamming_cost.sv
// census_hamming_cost: streaming Hamming matching cost for all candidate
// disparities, with winner-take-all disparity selection. Three-stage pipeline:
// S1 XOR against the right-vector history, S2 masked popcount, S3 argmin and output.
module census_hamming_cost #(
  parameter  int CVW   = 8,
  parameter  int DispN = 16,
  localparam int CostW = $clog2(CVW + 1),
  localparam int DispW = $clog2(DispN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     line_start,
  input  logic [CVW-1:0]           cvL,
  input  logic [CVW-1:0]           cvR,
  output logic                     out_valid,
  output logic [DispN*CostW-1:0]   out_cost,
  output logic [DispW-1:0]         out_best,
  output logic                     out_line_start
);

  // The oldest history slot would only ever feed disparity DispN, which does
  // not exist, so only DispN-1 right vectors are kept.
  logic [CVW-1:0]   hist_q [DispN-1];
  logic [CVW-1:0]   hist_d [DispN-1];
  logic [DispW-1:0] hcnt_q, hcnt_d;
  logic [DispW-1:0] pix_h;

  logic [CVW-1:0]   xor_q [DispN];
  logic [CVW-1:0]   xor_d [DispN];
  logic [DispN-1:0] mask_q, mask_d;
  logic             v1_q, v1_d, ls1_q, ls1_d;

  logic [CostW-1:0] cost2_q [DispN];
  logic [CostW-1:0] cost2_d [DispN];
  logic             v2_q, v2_d, ls2_q, ls2_d;

  logic [DispN*CostW-1:0] cost3_q, cost3_d;
  logic [DispW-1:0]       best3_q, best3_d;
  logic                   v3_q, v3_d, ls3_q, ls3_d;
  logic [CostW-1:0]       min_c;

  function automatic logic [CostW-1:0] popcnt(input logic [CVW-1:0] v);
    logic [CostW-1:0] c;
    c = '0;
    for (int i = 0; i < CVW; i++) c = c + CostW'(v[i]);
    return c;
  endfunction

  // History shift and saturating line position; hcnt resets to 0 so the
  // first pixel after reset is x=0 even without line_start.
  always_comb begin
    hist_d = hist_q;
    hcnt_d = hcnt_q;
    pix_h  = line_start ? '0 : hcnt_q;
    if (in_valid) begin
      hist_d[0] = cvR;
      for (int d = 1; d < DispN - 1; d++) hist_d[d] = hist_q[d-1];
      if (line_start)                         hcnt_d = DispW'(1);
      else if (hcnt_q != DispW'(DispN - 1))   hcnt_d = hcnt_q + DispW'(1);
    end
  end

  // S1: XOR of cvL against the right vector of pixel x-d, plus validity mask.
  always_comb begin
    xor_d    = xor_q;
    mask_d   = '0;
    xor_d[0] = cvL ^ cvR;
    for (int d = 1; d < DispN; d++) xor_d[d] = cvL ^ hist_q[d-1];
    for (int d = 0; d < DispN; d++) mask_d[d] = (d <= int'(pix_h));
    v1_d  = in_valid;
    ls1_d = in_valid & line_start;
  end

  // S2: popcount, with disparities reaching past the line start forced to max cost.
  always_comb begin
    cost2_d = cost2_q;
    for (int d = 0; d < DispN; d++)
      cost2_d[d] = mask_q[d] ? popcnt(xor_q[d]) : CostW'(CVW);
    v2_d  = v1_q;
    ls2_d = ls1_q;
  end

  // S3: pack costs and pick the lowest-index minimum; data holds across bubbles.
  always_comb begin
    cost3_d = cost3_q;
    best3_d = best3_q;
    min_c   = cost2_q[0];
    if (v2_q) begin
      best3_d = '0;
      for (int d = 0; d < DispN; d++) cost3_d[d*CostW +: CostW] = cost2_q[d];
      for (int d = 1; d < DispN; d++) begin
        if (cost2_q[d] < min_c) begin
          min_c   = cost2_q[d];
          best3_d = DispW'(d);
        end
      end
    end
    v3_d  = v2_q;
    ls3_d = v2_q & ls2_q;
  end

  // All state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DispN - 1; d++) hist_q[d] <= '0;
      for (int d = 0; d < DispN; d++) begin
        xor_q[d]   <= '0;
        cost2_q[d] <= '0;
      end
      hcnt_q  <= '0;
      mask_q  <= '0;
      v1_q    <= 1'b0;
      ls1_q   <= 1'b0;
      v2_q    <= 1'b0;
      ls2_q   <= 1'b0;
      cost3_q <= '0;
      best3_q <= '0;
      v3_q    <= 1'b0;
      ls3_q   <= 1'b0;
    end else begin
      for (int d = 0; d < DispN - 1; d++) hist_q[d] <= hist_d[d];
      for (int d = 0; d < DispN; d++) begin
        xor_q[d]   <= xor_d[d];
        cost2_q[d] <= cost2_d[d];
      end
      hcnt_q  <= hcnt_d;
      mask_q  <= mask_d;
      v1_q    <= v1_d;
      ls1_q   <= ls1_d;
      v2_q    <= v2_d;
      ls2_q   <= ls2_d;
      cost3_q <= cost3_d;
      best3_q <= best3_d;
      v3_q    <= v3_d;
      ls3_q   <= ls3_d;
    end
  end

  assign out_valid      = v3_q;
  assign out_cost       = cost3_q;
  assign out_best       = best3_q;
  assign out_line_start = ls3_q;

endmodule

// File: tb/tb_census_hamming_cost.sv
// Bench for census_hamming_cost: line-indexed reference model, fixed-latency
// expectation queue, table vectors for tie/new-line cases, directed and random streams.
module tb_census_hamming_cost;
  localparam int CVW = 8;
  localparam int DN  = 16;
  localparam int CW  = DN * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, line_start = 1'b0;
  logic [CVW-1:0] cvL = '0, cvR = '0;
  logic out_valid, out_line_start;
  logic [CW-1:0] out_cost;
  logic [3:0] out_best;

  census_hamming_cost #(.CVW(CVW), .DispN(DN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .line_start(line_start),
    .cvL(cvL), .cvR(cvR), .out_valid(out_valid), .out_cost(out_cost),
    .out_best(out_best), .out_line_start(out_line_start));

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit ls;
    logic [CW-1:0] cost; logic [3:0] best;
    bit has_tab; logic [CW-1:0] tcost; logic [3:0] tbest;
  } ent_t;

  typedef struct {
    bit ls; logic [7:0] l; logic [7:0] r;
    bit chk; logic [CW-1:0] cost; logic [3:0] best;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  ent_t pipe[$];
  logic [7:0] rline[$];   // right vectors of the current line, newest first
  int xpos;
  bit first_pix;
  logic [CW-1:0] last_cost;
  logic [3:0] last_best;
  logic [7:0] recent[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: cost(d) = popcount(cvL ^ right vector of pixel x-d) if x-d is on this line.
  task automatic model(input bit ls, input logic [7:0] l, input logic [7:0] r,
                       output logic [CW-1:0] cost, output logic [3:0] best);
    int c, bc;
    if (ls || first_pix) begin
      xpos = 0;
      rline.delete();
    end else xpos++;
    first_pix = 1'b0;
    rline.push_front(r);
    if (rline.size() > DN) void'(rline.pop_back());
    cost = '0; best = '0; bc = 99;
    for (int d = 0; d < DN; d++) begin
      if (d <= xpos) c = $countones(l ^ rline[d]);
      else c = CVW;
      cost[d*4 +: 4] = 4'(c);
      if (c < bc) begin bc = c; best = 4'(d); end
    end
  endtask

  task automatic model_reset();
    rline.delete();
    first_pix = 1'b1;
    pipe.delete();
    last_cost = '0;
    last_best = '0;
    for (int i = 0; i < 2; i++) begin
      ent_t b;
      b.v = 0; b.ls = 0; b.cost = '0; b.best = '0; b.has_tab = 0; b.tcost = '0; b.tbest = '0;
      pipe.push_back(b);
    end
  endtask

  task automatic step_t(input bit v, input bit ls, input logic [7:0] l, input logic [7:0] r,
                        input bit has_tab, input logic [CW-1:0] tcost, input logic [3:0] tbest);
    ent_t e, o;
    @(negedge clk);
    in_valid = v; line_start = ls; cvL = l; cvR = r;
    e.v = v; e.ls = ls; e.cost = '0; e.best = '0;
    e.has_tab = has_tab; e.tcost = tcost; e.tbest = tbest;
    if (v) begin
      model(ls, l, r, e.cost, e.best);
      recent.push_front(r);
      if (recent.size() > DN) void'(recent.pop_back());
    end
    pipe.push_back(e);
    @(posedge clk);
    #1;
    o = pipe.pop_front();
    chk("out_valid", 64'(out_valid), 64'(o.v));
    if (o.v) begin
      chk("out_cost", out_cost, o.cost);
      chk("out_best", 64'(out_best), 64'(o.best));
      chk("out_line_start", 64'(out_line_start), 64'(o.ls));
      last_cost = o.cost;
      last_best = o.best;
      if (o.has_tab) begin
        chk("tab_cost", out_cost, o.tcost);
        chk("tab_best", 64'(out_best), 64'(o.tbest));
      end
    end else begin
      chk("hold_cost", out_cost, last_cost);
      chk("hold_best", 64'(out_best), 64'(last_best));
    end
  endtask

  task automatic step(input bit v, input bit ls, input logic [7:0] l, input logic [7:0] r);
    step_t(v, ls, l, r, 1'b0, '0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_cost"}, out_cost, 64'd0);
    chk({nm, "_best"}, 64'(out_best), 64'd0);
    chk({nm, "_ls"}, 64'(out_line_start), 64'd0);
  endtask

  vec_t tab[8];
  logic [CW-1:0] all8, tmp;

  initial begin
    all8 = {DN{4'd8}};
    // tie / new-line table
    for (int i = 0; i < 8; i++) begin
      tab[i].ls = 0; tab[i].chk = 0; tab[i].cost = all8; tab[i].best = 0;
    end
    tab[0].ls = 1; tab[0].l = 8'h0E; tab[0].r = 8'h0E; tab[0].chk = 1;
    tmp = all8; tmp[3:0] = 4'd0; tab[0].cost = tmp;
    tab[1].l = 8'hF0; tab[1].r = 8'hF0;
    tab[2].l = 8'hF0; tab[2].r = 8'hF0;
    tab[3].l = 8'h1F; tab[3].r = 8'h1F;
    tab[4].l = 8'hF0; tab[4].r = 8'hF0;
    tab[5].l = 8'h0F; tab[5].r = 8'hF0; tab[5].chk = 1; tab[5].best = 4'd2;
    tmp = all8; tmp[2*4 +: 4] = 4'd1; tmp[5*4 +: 4] = 4'd1; tab[5].cost = tmp;
    tab[6].ls = 1; tab[6].l = 8'h00; tab[6].r = 8'h00; tab[6].chk = 1;
    tmp = all8; tmp[3:0] = 4'd0; tab[6].cost = tmp;
    tab[7].ls = 1; tab[7].l = 8'h33; tab[7].r = 8'h3C; tab[7].chk = 1;
    tmp = all8; tmp[3:0] = 4'd4; tab[7].cost = tmp;

    // reset held while inputs toggle
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); line_start = 1'($urandom);
      cvL = 8'($urandom); cvR = 8'($urandom);
      @(posedge clk); #1;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    in_valid = 0; line_start = 0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 8'($urandom), 8'($urandom));

    // identical stream
    for (int x = 0; x <= 20; x++) step(1, x == 0, 8'hA5, 8'hA5);
    drain();

    // shift match, unstalled then stalled
    for (int run = 0; run < 2; run++) begin
      for (int x = 0; x < 20; x++) begin
        if (run == 1 && x == 9) for (int k = 0; k < 5; k++) step(0, 0, 8'hFF, 8'hFF);
        step(1, x == 0, (x >= 3) ? 8'(x - 3) : 8'(x), 8'(x));
      end
      drain();
    end

    // table vectors: tie, new line, consecutive line starts
    for (int i = 0; i < 8; i++)
      step_t(1, tab[i].ls, tab[i].l, tab[i].r, tab[i].chk, tab[i].cost, tab[i].best);
    drain();

    // reset with two pixels in flight
    for (int x = 0; x < 6; x++) step(1, x == 0, 8'(x * 17), 8'(x * 17));
    step(1, 0, 8'h5A, 8'h5A);
    step(1, 0, 8'hC3, 8'hC3);
    @(negedge clk);
    in_valid = 0; line_start = 0;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 8'h00, 8'h00);
    step(1, 0, 8'h5A, 8'h5A);
    step(1, 0, 8'h5A, 8'hA5);
    drain();

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      bit v, ls;
      logic [7:0] l, r;
      v  = ($urandom_range(0, 9) < 7);
      ls = ($urandom_range(0, 19) == 0);
      r  = 8'($urandom);
      if (recent.size() > 0 && $urandom_range(0, 1) == 1)
        l = recent[$urandom_range(0, recent.size() - 1)] ^ (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      else l = 8'($urandom);
      step(v, ls, l, r);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/census_hamming_cost.md
# census_hamming_cost

Streaming matching-cost stage that sits directly downstream of the census-vector comparators in the SGM pipeline. For each incoming pixel it takes the left-image census vector and the right-image census vector. It keeps a per-line history of the last DispN right vectors and emits, three cycles later, the Hamming cost for every candidate disparity. It also emits the winner-take-all disparity. Its outputs feed the SGM path-aggregation stage.

## Interface
- CVW, 8, census vector width in bits.
- DispN, 16, number of candidate disparities (d = 0..DispN-1), ≥ 2.
- CostW (localparam) = $clog2(CVW+1), width of one cost (4 for CVW=8).
- DispW (localparam) = $clog2(DispN), width of a disparity index.

- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  cvL/cvR/line_start are valid this cycle.
- line_start  in  1  current pixel is pixel x=0 of a line; ignored when in_valid=0.
- cvL  in  CVW  left census vector for pixel x.
- cvR  in  CVW  right census vector for pixel x.
- out_valid  out  1  out_cost/out_best are valid.
- out_cost  out  DispN*CostW  cost for disparity d in bits [d*CostW +: CostW].
- out_best  out  DispW  disparity with minimum cost; lowest index wins ties.
- out_line_start  out  1  line_start delayed with the data.

## Operation
- Right history H[0..DispN-1], each CVW bits.
  - On an accepted pixel (in_valid=1): H[0]←cvR, H[d]←H[d-1] for d≥1.
  - With the shift, cost for disparity d compares cvL against the right vector of pixel x-d: d=0 uses the incoming cvR, d≥1 uses the pre-shift H[d-1].
- Line position counter hcnt, 0..DispN-1, saturating.
  - Accepted pixel with line_start=1: the pixel is treated as hcnt=0, then hcnt←1.
  - Accepted pixel without line_start: hcnt←min(hcnt+1, DispN-1).
  - Disparity d is valid for a pixel iff d ≤ its hcnt. The first pixel after reset is treated as x=0 even if line_start=0.
- Cost for d:
  - popcount(cvL XOR Rd) if valid.
  - CVW (the maximum cost) if invalid, i.e. history from the previous line or absent.
  - Range 0..CVW, never wraps.
- out_best: argmin over all DispN costs; ties go to the lowest d. Invalid disparities carry cost CVW, so they only win if every cost is CVW; then out_best is 0.
- in_valid=0: no history shift, no hcnt change, a bubble enters the pipeline.
- No backpressure. A downstream stall is not supported; the consumer must accept every out_valid cycle.

## Timing
- Pipeline, fixed latency 3 cycles from an in_valid cycle to its out_valid cycle:
  - S1: register cvL XOR Rd for all d, plus the valid mask, valid, and line_start.
  - S2: register popcounts, with masked costs forced to CVW.
  - S3: register out_cost, out_best (argmin over S2 costs), out_valid, and out_line_start.
- The valid bit travels with the data every cycle regardless of in_valid. Bubbles appear at the output exactly 3 cycles after they enter.
- Throughput: one pixel per cycle sustained.
- Reset (asynchronous assert, deassertion synchronous to clk):
  - H all zero, hcnt=0, all pipeline registers zero.
  - out_valid=0, out_cost=0, out_best=0, out_line_start=0.
- Reset mid-line: in-flight pixels are discarded, with no out_valid for them. The next accepted pixel is treated as x=0.
- line_start on consecutive accepted pixels: each pixel is x=0, so only d=0 is valid for each.
- When out_valid=0, out_cost and out_best hold their last values; consumers qualify them with out_valid.

## Test plan
- Reset: hold rst_n=0 while toggling inputs -> all outputs 0. Release, then send no in_valid for 10 cycles -> out_valid stays 0.
- Identical stream, CVW=8, DispN=16: line_start on pixel 0, then 20 pixels all with cvL=cvR=8'hA5.
  - Pixel 0 -> cost[0]=0, cost[1..15]=8, best=0.
  - Pixel 20 -> all costs 0, best=0.
  - Each out_valid appears exactly 3 cycles after its in_valid.
- Shift match: cvR(x)=x, cvL(x)=x-3 for x≥3.
  - For x≥3 -> cost[3]=0, best=3.
  - At x=2 -> cost[3..15]=8.
- Stall: same stream with in_valid deasserted for 5 cycles mid-line -> identical costs per pixel as the unstalled run, with a 5-cycle gap in out_valid.
- New line: after 20 pixels, assert line_start with cvL=cvR=0 -> that pixel has cost[0]=0, cost[1..15]=8, and out_line_start=1 with the data.
- Tie and reset mid-operation:
  - cvL=8'h0F with history giving cost[2]=cost[5]=1 as the minimum -> best=2.
  - Assert rst_n=0 for one cycle with 2 pixels in flight -> neither emerges, and the next pixel behaves as x=0.
